// File: rtl/pc_fetch_ctrl.sv
// PC sequencing and instruction-fetch controller: drives the PC register load port and the imem request.
// Optional build macro PC_FETCH_ALIGN_CHECK_EN replaces misaligned jump/branch targets with EXC_VEC and adds a misalign pulse.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_BOOT   | first cycle after reset, loads RESET_VEC into the PC
// ST_FETCH  | issuing fetches, tracking outstanding request and redirects
// ST_HALTED | no fetches; waits for resume or an exception
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] EXC_VEC   = 32'h0000_0004,
    parameter int unsigned PC_STEP   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_cur,
    output logic [31:0] pc_next,
    output logic        pc_ena,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        exc,
    input  logic        halt,
    input  logic        resume,
`ifdef PC_FETCH_ALIGN_CHECK_EN
    output logic        misalign,
`endif
    output logic        halted
);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic        req_out, req_out_nxt;
    logic        pend_valid, pend_valid_nxt;
    logic [31:0] pend_tgt, pend_tgt_nxt;

    logic        redir;
    logic [31:0] redir_raw;
    logic [31:0] redir_tgt;
    logic [31:0] pc_seq;

    assign redir     = exc | jump | branch_taken;
    assign redir_raw = exc ? EXC_VEC : (jump ? jump_target : branch_target);
    assign pc_seq    = pc_cur + 32'(PC_STEP);
    assign imem_addr = pc_cur;
    assign instr     = imem_rdata;

`ifdef PC_FETCH_ALIGN_CHECK_EN
    logic tgt_bad;
    logic mis_sel;

    assign tgt_bad   = ~exc & (redir_raw[1:0] != 2'b00);
    assign redir_tgt = tgt_bad ? EXC_VEC : redir_raw;
    assign misalign  = mis_sel & tgt_bad;
`else
    assign redir_tgt = redir_raw;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_BOOT;
            req_out    <= 1'b0;
            pend_valid <= 1'b0;
            pend_tgt   <= 32'h0000_0000;
        end else begin
            state      <= state_nxt;
            req_out    <= req_out_nxt;
            pend_valid <= pend_valid_nxt;
            pend_tgt   <= pend_tgt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        req_out_nxt    = req_out;
        pend_valid_nxt = pend_valid;
        pend_tgt_nxt   = pend_tgt;
        pc_ena         = 1'b0;
        pc_next        = pc_seq;
        imem_req       = 1'b0;
        instr_valid    = 1'b0;
`ifdef PC_FETCH_ALIGN_CHECK_EN
        mis_sel        = 1'b0;
`endif

        case (state)
            ST_BOOT: begin
                pc_ena         = 1'b1;
                pc_next        = RESET_VEC;
                req_out_nxt    = 1'b0;
                pend_valid_nxt = 1'b0;
                state_nxt      = ST_FETCH;
            end

            ST_FETCH: begin
                imem_req    = req_out | ~stall;
                req_out_nxt = imem_req & ~imem_ack;
`ifdef PC_FETCH_ALIGN_CHECK_EN
                // every redirect seen in FETCH is either applied or latched
                mis_sel     = redir;
`endif
                if (imem_req && imem_ack) begin
                    instr_valid    = ~pend_valid & ~redir;
                    pc_ena         = 1'b1;
                    if (redir)
                        pc_next = redir_tgt;
                    else if (pend_valid)
                        pc_next = pend_tgt;
                    else
                        pc_next = pc_seq;
                    pend_valid_nxt = 1'b0;
                end else if (imem_req) begin
                    // address must hold until ack, so the redirect waits
                    if (redir) begin
                        pend_valid_nxt = 1'b1;
                        pend_tgt_nxt   = redir_tgt;
                    end
                end else if (redir || pend_valid) begin
                    pc_ena         = 1'b1;
                    pc_next        = redir ? redir_tgt : pend_tgt;
                    pend_valid_nxt = 1'b0;
                end

                if (halt && (!imem_req || imem_ack))
                    state_nxt = ST_HALTED;
            end

            ST_HALTED: begin
                if (exc) begin
                    pc_ena    = 1'b1;
                    pc_next   = EXC_VEC;
                    state_nxt = ST_FETCH;
                end else if (resume) begin
                    state_nxt = ST_FETCH;
                end
            end

            default: begin
                state_nxt = ST_BOOT;
            end
        endcase

        if (rst) begin
            pc_ena      = 1'b0;
            pc_next     = RESET_VEC;
            imem_req    = 1'b0;
            instr_valid = 1'b0;
`ifdef PC_FETCH_ALIGN_CHECK_EN
            mis_sel     = 1'b0;
`endif
        end
    end

    assign halted = (state == ST_HALTED) & ~rst;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios followed by random stimulus against a behavioural model.
// The bench owns the PC register, loading it from the model's expected pc_next whenever a load is expected.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] EXC_VEC   = 32'h0000_0004;

    localparam int MODE_BOOT = 0;
    localparam int MODE_RUN  = 1;
    localparam int MODE_HALT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_cur;
    logic [31:0] pc_next;
    logic        pc_ena;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        exc;
    logic        halt;
    logic        resume;
    logic        halted;
`ifdef PC_FETCH_ALIGN_CHECK_EN
    logic        misalign;
`endif

    always #5 clk = ~clk;

    pc_fetch_ctrl #(
        .RESET_VEC(RESET_VEC),
        .EXC_VEC  (EXC_VEC),
        .PC_STEP  (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_cur       (pc_cur),
        .pc_next      (pc_next),
        .pc_ena       (pc_ena),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .exc          (exc),
        .halt         (halt),
        .resume       (resume),
`ifdef PC_FETCH_ALIGN_CHECK_EN
        .misalign     (misalign),
`endif
        .halted       (halted)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // model state: operating mode, whether a fetch is in flight, deferred redirect (0 or 1 entries)
    int          m_mode;
    bit          m_out;
    logic [31:0] m_pend[$];
    int          n_mode;
    bit          n_out;
    logic [31:0] n_pend[$];

    logic        e_req, e_ena, e_iv, e_halted, e_mis;
    logic [31:0] e_next;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sel_target(output bit bad);
        logic [31:0] t;
        bad = 1'b0;
        t = exc ? EXC_VEC : (jump ? jump_target : branch_target);
`ifdef PC_FETCH_ALIGN_CHECK_EN
        if (!exc && t[1:0] != 2'b00) begin
            bad = 1'b1;
            t   = EXC_VEC;
        end
`endif
        return t;
    endfunction

    task automatic model_reset();
        m_mode = MODE_BOOT;
        m_out  = 1'b0;
        m_pend = {};
    endtask

    task automatic model_eval();
        bit          redir;
        bit          bad;
        logic [31:0] tgt;
        e_req = 0; e_ena = 0; e_iv = 0; e_halted = 0; e_mis = 0; e_next = 'x;
        n_mode = m_mode; n_out = m_out; n_pend = m_pend;
        redir = exc | jump | branch_taken;
        tgt   = sel_target(bad);
        if (rst) begin
            e_next = RESET_VEC;
            n_mode = MODE_BOOT;
            n_out  = 1'b0;
            n_pend = {};
            return;
        end
        case (m_mode)
            MODE_BOOT: begin
                e_ena  = 1; e_next = RESET_VEC;
                n_mode = MODE_RUN; n_out = 0; n_pend = {};
            end
            MODE_RUN: begin
                e_req = m_out || !stall;
                e_mis = redir && bad;
                if (e_req && imem_ack) begin
                    e_ena = 1;
                    e_iv  = (m_pend.size() == 0) && !redir;
                    if (redir)                  e_next = tgt;
                    else if (m_pend.size() > 0) e_next = m_pend[0];
                    else                        e_next = pc_cur + 32'd4;
                    n_pend = {};
                    n_out  = 0;
                end else if (e_req) begin
                    n_out = 1;
                    if (redir) n_pend = {tgt};
                end else begin
                    n_out = 0;
                    if (redir) begin
                        e_ena = 1; e_next = tgt; n_pend = {};
                    end else if (m_pend.size() > 0) begin
                        e_ena = 1; e_next = m_pend[0]; n_pend = {};
                    end
                end
                if (halt && (!e_req || imem_ack)) n_mode = MODE_HALT;
            end
            default: begin
                e_halted = 1;
                if (exc) begin
                    e_ena = 1; e_next = EXC_VEC; n_mode = MODE_RUN;
                end else if (resume) begin
                    n_mode = MODE_RUN;
                end
            end
        endcase
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".imem_req"},    imem_req,    e_req);
        check({tag, ".imem_addr"},   imem_addr,   pc_cur);
        check({tag, ".pc_ena"},      pc_ena,      e_ena);
        check({tag, ".instr_valid"}, instr_valid, e_iv);
        check({tag, ".instr"},       instr,       imem_rdata);
        check({tag, ".halted"},      halted,      e_halted);
        if (e_ena || rst) check({tag, ".pc_next"}, pc_next, e_next);
`ifdef PC_FETCH_ALIGN_CHECK_EN
        check({tag, ".misalign"},    misalign,    e_mis);
`endif
    endtask

    // one clock: compare at the falling edge, advance model and PC register after the rising edge
    task automatic step(input string tag);
        @(negedge clk);
        model_eval();
        compare_all(tag);
        @(posedge clk);
        if (e_ena) pc_cur = e_next;
        m_mode = n_mode;
        m_out  = n_out;
        m_pend = n_pend;
        #1;
    endtask

    task automatic clear_inputs();
        imem_ack = 0; stall = 0; branch_taken = 0; jump = 0; exc = 0;
        halt = 0; resume = 0;
        branch_target = 32'h0; jump_target = 32'h0;
    endtask

    // assert rst mid-cycle and check outputs react before any clock edge
    task automatic async_reset(input string tag);
        #2;
        rst = 1;
        #1;
        model_eval();
        compare_all(tag);
        check({tag, ".rst_pc_ena"}, pc_ena, 1'b0);
        check({tag, ".rst_req"},    imem_req, 1'b0);
        model_reset();
        step({tag, ".hold"});
        rst = 0;
    endtask

    function automatic logic [31:0] rnd_target();
        logic [31:0] t;
        t = $urandom;
`ifndef PC_FETCH_ALIGN_CHECK_EN
        t[1:0] = 2'b00;
`else
        if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
`endif
        return t;
    endfunction

    initial begin
        rst = 1;
        clear_inputs();
        imem_rdata = 32'h1234_5678;
        pc_cur = 32'hDEAD_BEE0;
        model_reset();
        #2;
        model_eval();
        compare_all("reset");
        check("reset.pc_next", pc_next, RESET_VEC);
        step("reset_hold");
        rst = 0;

        // 1: boot then straight-line fetches
        imem_ack = 1;
        step("t1_boot");
        for (int i = 0; i < 4; i++) begin
            imem_rdata = $urandom;
            #1;
            check("t1_addr", imem_addr, 32'(i * 4));
            check("t1_iv", instr_valid, 1'b1);
            step("t1_fetch");
        end

        // 2: jump arrives while the fetch at 0x10 is outstanding
        imem_ack = 0; jump = 1; jump_target = 32'h80;
        #1 check("t2_addr_hold", imem_addr, 32'h10);
        step("t2_c1");
        jump = 0;
        step("t2_c2");
        step("t2_c3");
        imem_ack = 1;
        #1;
        check("t2_iv_at_ack", instr_valid, 1'b0);
        check("t2_next", pc_next, 32'h80);
        step("t2_ack");
        #1 check("t2_refetch", imem_addr, 32'h80);
        step("t2_fetch80");

        // 3: simultaneous redirects, exception wins
        exc = 1; jump = 1; jump_target = 32'h40; branch_taken = 1; branch_target = 32'h20;
        #1;
        check("t3_next", pc_next, EXC_VEC);
        check("t3_iv", instr_valid, 1'b0);
        step("t3");
        clear_inputs();

        // 4: branch while stalled with nothing outstanding
        stall = 1; branch_taken = 1; branch_target = 32'h200;
        #1;
        check("t4_req", imem_req, 1'b0);
        check("t4_ena", pc_ena, 1'b1);
        check("t4_next", pc_next, 32'h200);
        step("t4_stall");
        clear_inputs();
        imem_ack = 1;
        #1 check("t4_addr", imem_addr, 32'h200);
        step("t4_fetch");

        // 5: halt/resume and exception out of halt
        jump = 1; jump_target = 32'h30;
        step("t5_jump30");
        jump = 0; halt = 1;
        #1 check("t5_next", pc_next, 32'h34);
        step("t5_halt");
        halt = 0; imem_ack = 0;
        #1;
        check("t5_halted", halted, 1'b1);
        check("t5_noreq", imem_req, 1'b0);
        step("t5_h1");
        step("t5_h2");
        resume = 1;
        step("t5_resume");
        resume = 0; imem_ack = 1;
        #1 check("t5_addr34", imem_addr, 32'h34);
        step("t5_fetch34");
        halt = 1;
        step("t5_halt2");
        halt = 0; exc = 1; jump = 1; jump_target = 32'h100;
        #1;
        check("t5_exc_ena", pc_ena, 1'b1);
        check("t5_exc_next", pc_next, EXC_VEC);
        step("t5_exc");
        clear_inputs();
        imem_ack = 1;
        #1 check("t5_addr4", imem_addr, EXC_VEC);
        step("t5_fetch4");

        // 6: PC wrap and reset during an outstanding fetch
        jump = 1; jump_target = 32'hFFFF_FFFC;
        step("t6_jump");
        jump = 0;
        #1 check("t6_wrap", pc_next, 32'h0);
        step("t6_wrapfetch");
        imem_ack = 0;
        step("t6_outstanding");
        imem_ack = 1;
        async_reset("t6_rst");
        #1 check("t6_boot_iv", instr_valid, 1'b0);
        step("t6_boot");

        // random traffic against the model
        for (int c = 0; c < 1500; c++) begin
            imem_ack      = ($urandom_range(0, 1) == 1);
            stall         = ($urandom_range(0, 9) < 3);
            branch_taken  = ($urandom_range(0, 99) < 8);
            jump          = ($urandom_range(0, 99) < 5);
            exc           = ($urandom_range(0, 99) < 3);
            halt          = ($urandom_range(0, 99) < 5);
            resume        = ($urandom_range(0, 4) == 0);
            branch_target = rnd_target();
            jump_target   = rnd_target();
            imem_rdata    = $urandom;
            if ($urandom_range(0, 249) == 0)
                async_reset("rnd_rst");
            else
                step("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Sequencing controller for the 32-bit PC register and the instruction-memory fetch port.
- Issues fetch requests at the current PC, selects the next PC, and drives the register's enable and data input.
- Next-PC sources: sequential +4, branch, jump, exception vector.
- Handles stall, halt/resume, and redirects that arrive while a fetch is outstanding.

Parameters:
RESET_VEC, 32'h0000_0000, PC loaded by the boot cycle after reset
EXC_VEC, 32'h0000_0004, PC loaded on exception
PC_STEP, 4, sequential increment in bytes

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
pc_cur  in  32  current value from the PC register output
pc_next  out  32  data input to the PC register
pc_ena  out  1  load enable for the PC register
imem_req  out  1  fetch request
imem_addr  out  32  fetch address, always equal to pc_cur
imem_ack  in  1  fetch complete; valid only while imem_req=1
imem_rdata  in  32  fetched word
instr_valid  out  1  instr carries a valid, non-discarded fetch this cycle
instr  out  32  imem_rdata passthrough
stall  in  1  downstream not ready; blocks new requests
branch_taken  in  1  branch redirect
branch_target  in  32  branch target
jump  in  1  jump redirect
jump_target  in  32  jump target
exc  in  1  exception redirect
halt  in  1  halt request
resume  in  1  leave HALTED
halted  out  1  state==HALTED

Behaviour:
- Registered state:
  - FSM: BOOT, FETCH, HALTED.
  - req_out: a request is outstanding.
  - pend_valid / pend_tgt: deferred redirect.
- Reset (async) values: state=BOOT, req_out=0, pend_valid=0, pend_tgt=0.
- Outputs during reset: pc_ena=0, imem_req=0, instr_valid=0, halted=0, pc_next=RESET_VEC.
- All outputs are combinational from state, registers and inputs. PC updates take effect on the edge where pc_ena=1.
- Redirect: redir = exc|jump|branch_taken.
  - Target priority: EXC_VEC, then jump_target, then branch_target.
- BOOT: pc_ena=1, pc_next=RESET_VEC; next state FETCH. All inputs are ignored.
- FETCH:
  - imem_req = req_out | ~stall.
  - req_out next = imem_req & ~imem_ack.
- FETCH, imem_req=1 and imem_ack=1:
  - instr_valid = ~pend_valid & ~redir.
  - pc_ena=1.
  - pc_next = redir target if redir; else pend_tgt if pend_valid; else pc_cur+PC_STEP (mod 2^32, wraps FFFF_FFFC to 0000_0000).
  - pend_valid cleared.
- FETCH, imem_req=1 and imem_ack=0:
  - pc_ena=0. The address must stay stable until ack.
  - If redir: pend_valid=1, pend_tgt = redir target. A newer redirect overwrites the older one.
- FETCH, imem_req=0 (stalled, nothing outstanding):
  - If redir or pend_valid: pc_ena=1, pc_next = redir target (else pend_tgt); pend_valid cleared.
  - Otherwise pc_ena=0.
- Halt, checked only in FETCH:
  - Accepted on a cycle with (imem_req=0) or (imem_ack=1); next state HALTED. The PC update for that cycle still occurs.
  - Otherwise halt is ignored that cycle; the caller holds it.
- HALTED:
  - imem_req=0, pc_ena=0.
  - exc: pc_ena=1, pc_next=EXC_VEC, go to FETCH.
  - resume: go to FETCH (exc has priority over resume).
  - branch/jump ignored.
- instr_valid=0 in every case not listed above.
- rst mid-fetch: the outstanding request is abandoned, the pending redirect is dropped, and the boot sequence restarts. Any ack arriving while in BOOT is ignored.

Optional Feature:
PC_FETCH_ALIGN_CHECK_EN:
- Defined:
  - A selected jump/branch target with [1:0]≠0 is replaced by EXC_VEC.
  - Extra output misalign (1 bit) pulses in the cycle the replacement is selected.
  - It also applies when the replacement is latched into pending.
- Undefined: targets are used unchecked and the misalign port is absent.

Test Plan:
1. Reset then release, ack tied 1, no stall → BOOT loads 0; fetches at 0,4,8,C with instr_valid=1 each cycle.
2. pc_cur=0x10, req held with ack=0 for 3 cycles, jump_target=0x80 pulsed in cycle 1, then ack → instr_valid=0 at ack; pc_next=0x80; the next fetch is at 0x80.
3. Same cycle: exc=1, jump=1 (0x40), branch_taken=1 (0x20), ack=1 → pc_next=EXC_VEC=0x4, instr_valid=0.
4. stall=1 with no outstanding request, branch_target=0x200 → imem_req=0, pc_ena=1, pc_next=0x200; stall drop → fetch at 0x200.
5. halt with ack at pc_cur=0x30 → PC becomes 0x34, halted=1, no requests; resume → fetch at 0x34. Repeat with exc while halted → fetch at 0x4.
6. pc_cur=0xFFFF_FFFC with ack → pc_next=0x0. Separately, rst asserted mid-request → all outputs at reset values in the same cycle.
